// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and default bit period
package uart_pkg;

  localparam int BAUD_PER_DEF = 10416;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchroniser for the asynchronous rx line, resets to idle-high
module uart_sync (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling, framing-error and overrun reporting
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_PER = BAUD_PER_DEF,
  parameter int HALF_PER = BAUD_PER / 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [13:0] BAUD_C = 14'(BAUD_PER);
  localparam logic [13:0] HALF_C = 14'(HALF_PER);

  uart_state_e state_q;
  logic [13:0] ctr_q;
  logic [2:0]  bit_ctr_q;
  logic [7:0]  sr_q;
  logic [7:0]  dout_q;
  logic        valid_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        rxs;

  uart_sync u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (rx),
    .q_o  (rxs)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= S_IDLE;
      ctr_q       <= 14'd0;
      bit_ctr_q   <= 3'd0;
      sr_q        <= 8'd0;
      dout_q      <= 8'd0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      // A read clears the holding flags; an accept in the same cycle overrides valid below.
      if (rd) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          ctr_q <= 14'd0;
          if (!rxs) state_q <= S_START;
        end
        S_START: begin
          if (ctr_q == HALF_C) begin
            ctr_q     <= 14'd0;
            bit_ctr_q <= 3'd0;
            state_q   <= rxs ? S_IDLE : S_DATA;
          end else begin
            ctr_q <= ctr_q + 14'd1;
          end
        end
        S_DATA: begin
          if (ctr_q == BAUD_C) begin
            ctr_q <= 14'd0;
            sr_q  <= {rxs, sr_q[7:1]};
            if (bit_ctr_q == 3'd7) state_q <= S_STOP;
            else                   bit_ctr_q <= bit_ctr_q + 3'd1;
          end else begin
            ctr_q <= ctr_q + 14'd1;
          end
        end
        S_STOP: begin
          if (ctr_q == BAUD_C) begin
            ctr_q <= 14'd0;
            if (rxs) begin
              state_q <= S_IDLE;
              if (!valid_q || rd) begin
                dout_q  <= sr_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            ctr_q <= ctr_q + 14'd1;
          end
        end
        S_BREAK: begin
          ctr_q <= 14'd0;
          if (rxs) state_q <= S_IDLE;
        end
        default: begin
          ctr_q   <= 14'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0;
  int fe0;
  logic busy_ok;

  uart_rx #(.BAUD_PER(15)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rx        (rx),
    .rd        (rd),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_cnt++;

  // Transmitter model: start, 8 data bits LSB first, stop; rd pulses for the edge after rd_cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int rd_cycle);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    for (int c = 0; c < 160; c++) begin
      @(posedge clk); #1;
      rx = bits[c / 16];
      rd = (c == rd_cycle);
    end
    rd = 1'b0;
  endtask

  task automatic pulse_rd();
    @(posedge clk); #1; rd = 1'b1;
    @(posedge clk); #1; rd = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0; rx = 1'b1; rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL reset_dout got %h want 00", dout); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun got %b want 0", overrun); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    nrst = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_loopback();
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, -1);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL lb_valid got %b want 1", valid); end
    vectors++; if (dout !== 8'hA5) begin miscompares++; $display("FAIL lb_dout got %h want a5", dout); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL lb_overrun got %b want 0", overrun); end
    vectors++; if (fe_cnt !== fe0) begin miscompares++; $display("FAIL lb_frame_err got %0d pulses want 0", fe_cnt - fe0); end
    pulse_rd();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL lb_rd_valid got %b want 0", valid); end
  endtask

  task automatic test_glitch();
    fe0 = fe_cnt;
    @(posedge clk); #1; rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_start got %b want 1", busy); end
    rx = 1'b1;
    busy_ok = 1'b0;
    for (int i = 0; i < 10 && !busy_ok; i++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b1;
    end
    vectors++; if (busy_ok !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_idle got busy=%b want 0 within 10", busy); end
    repeat (20) @(posedge clk);
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid got %b want 0", valid); end
    vectors++; if (fe_cnt !== fe0) begin miscompares++; $display("FAIL glitch_frame_err got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  task automatic test_break();
    fe0 = fe_cnt;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1; rx = 1'b0;
    end
    vectors++; if (fe_cnt !== fe0 + 1) begin miscompares++; $display("FAIL brk_frame_err got %0d pulses want 1", fe_cnt - fe0); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL brk_valid got %b want 0", valid); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL brk_busy_low got %b want 1", busy); end
    rx = 1'b1;
    busy_ok = 1'b0;
    for (int i = 0; i < 10 && !busy_ok; i++) begin
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b1;
    end
    vectors++; if (busy_ok !== 1'b1) begin miscompares++; $display("FAIL brk_busy_release got busy=%b want 0", busy); end
    send_frame(8'h3C, 1'b1, -1);
    vectors++; if (dout !== 8'h3C) begin miscompares++; $display("FAIL brk_next_dout got %h want 3c", dout); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL brk_next_valid got %b want 1", valid); end
    pulse_rd();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    vectors++; if (dout !== 8'h11) begin miscompares++; $display("FAIL ovr_dout got %h want 11", dout); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid got %b want 1", valid); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag got %b want 1", overrun); end
    pulse_rd();
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ovr_rd_valid got %b want 0", valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_rd_flag got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, -1);
    vectors++; if (dout !== 8'h11) begin miscompares++; $display("FAIL b2b_first_dout got %h want 11", dout); end
    // Stop sample lands on the edge after cycle 154 of the frame.
    send_frame(8'h22, 1'b1, 154);
    vectors++; if (dout !== 8'h22) begin miscompares++; $display("FAIL b2b_dout got %h want 22", dout); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %b want 1", valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL b2b_overrun got %b want 0", overrun); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    fe0 = fe_cnt;
    send_frame(8'h33, 1'b1, -1);
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL rst_pre_overrun got %b want 1", overrun); end
    bits = {1'b1, 8'hFF, 1'b0};
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1; rx = bits[c / 16];
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy got %b want 1", busy); end
    nrst = 1'b0;
    @(posedge clk); #1;
    vectors++; if (dout !== 8'h00) begin miscompares++; $display("FAIL rst_mid_dout got %h want 00", dout); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %b want 0", valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_mid_overrun got %b want 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    nrst = 1'b1;
    for (int c = 0; c < 120; c++) begin
      @(posedge clk); #1; rx = 1'b1;
    end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_tail_valid got %b want 0", valid); end
    send_frame(8'h5A, 1'b1, -1);
    vectors++; if (dout !== 8'h5A) begin miscompares++; $display("FAIL rst_next_dout got %h want 5a", dout); end
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL rst_next_valid got %b want 1", valid); end
    vectors++; if (fe_cnt !== fe0) begin miscompares++; $display("FAIL rst_next_frame_err got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_glitch();
    test_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
